// File: rtl/add_operand_sequencer_if.sv
// Handshake bundle between the byte source, the operand sequencer, the
// external combinational adder and the result sink.
interface add_operand_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic [7:0]       adder_a;
  logic [7:0]       adder_b;
  logic [8:0]       adder_sum;
  logic             out_valid;
  logic             out_ready;
  logic [8:0]       out;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  in_valid, in_data, adder_sum, out_ready,
    output in_ready, adder_a, adder_b, out_valid, out, op_count
  );

  modport master (
    output in_valid, in_data, adder_sum, out_ready,
    input  in_ready, adder_a, adder_b, out_valid, out, op_count
  );
endinterface

// File: rtl/add_operand_sequencer.sv
// Collects operand bytes A then B, lets the external adder settle for one
// cycle, then holds the 9-bit result until downstream takes it.
module add_operand_sequencer #(
  parameter int CNT_W = 8
) (
  input logic                   clk,
  input logic                   rst,
  add_operand_sequencer_if.slave bus
);
  typedef enum logic [1:0] {GET_A, GET_B, CALC, SEND} state_e;

  state_e           state_q;
  logic [7:0]       reg_a_q, reg_b_q;
  logic [8:0]       out_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q;
  logic             in_rdy, in_xfer;

  // Ready is gated by rst directly so no byte is taken during a reset cycle.
  assign in_rdy  = !rst && (state_q == GET_A || state_q == GET_B);
  assign in_xfer = bus.in_valid && in_rdy;
  assign cnt_d   = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= GET_A;
      reg_a_q     <= '0;
      reg_b_q     <= '0;
      out_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        GET_A: if (in_xfer) begin
          reg_a_q <= bus.in_data;
          state_q <= GET_B;
        end
        GET_B: if (in_xfer) begin
          reg_b_q <= bus.in_data;
          state_q <= CALC;
        end
        CALC: begin
          out_q       <= bus.adder_sum;
          out_valid_q <= 1'b1;
          state_q     <= SEND;
        end
        SEND: if (bus.out_ready) begin
          cnt_q       <= cnt_d;
          out_valid_q <= 1'b0;
          state_q     <= GET_A;
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= GET_A;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.adder_a   = reg_a_q;
  assign bus.adder_b   = reg_b_q;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.op_count  = cnt_q;
endmodule
